// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the halfword RAM adapter
// Contents:
//   DEF_RAM_ADDR_W / DEF_RAM_DATA_W  default RAM geometry (256 x 16)
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD  req_size encodings (2'b11 reserved)
//   adapter_state_e                    adapter FSM states
package mem_pkg;
    localparam int DEF_RAM_ADDR_W = 8;
    localparam int DEF_RAM_DATA_W = 16;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    typedef enum logic {IDLE, WR_HI} adapter_state_e;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: load lane select and sign/zero extension to 32 bits
// Ports:
//   data_i      {ram_out_ii, ram_out_i}, the two halfwords at h+1 and h
//   size_i      request size; size_i[1] set means word (covers reserved 11)
//   lane_i      byte lane within the halfword (byte address bit 0)
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   result_o    aligned, extended load result
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        lane_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);
    logic [7:0] b;
    assign b = lane_i ? data_i[15:8] : data_i[7:0];
    assign result_o = size_i[1] ? data_i :
                      size_i == SIZE_HALF ? {{16{~unsigned_i & data_i[15]}}, data_i[15:0]} :
                      {{24{~unsigned_i & b[7]}}, b};
endmodule

// File: rtl/mem_word_adapter.sv
// mem_word_adapter: 32-bit byte-addressed load/store port onto a 16-bit halfword RAM
// Optional feature macro: MEM_ACCESS_FAULT_EN (misaligned half/word and size 11 fault
// with rsp_err instead of being force-aligned).
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake; ready only in IDLE
//   req_we, req_size            store flag, size (00 byte, 01 half, 10 word)
//   req_unsigned                zero-extend loads when set
//   req_addr, req_wdata         byte address, LSB-aligned store data
//   rsp_valid/rsp_rdata/rsp_err one-cycle completion, load data, fault flag
//   ram_read_i/ram_read_ii      async read addresses h and h+1
//   ram_out_i/ram_out_ii        async read data
//   ram_write_addr/_data, ram_we  RAM write port
module mem_word_adapter
    import mem_pkg::*;
#(
    parameter int RAM_ADDR_W  = DEF_RAM_ADDR_W,
    parameter int RAM_DATA_W  = DEF_RAM_DATA_W,
    parameter int BYTE_ADDR_W = RAM_ADDR_W + 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [BYTE_ADDR_W-1:0] req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [RAM_ADDR_W-1:0]  ram_read_i,
    output logic [RAM_ADDR_W-1:0]  ram_read_ii,
    input  logic [RAM_DATA_W-1:0]  ram_out_i,
    input  logic [RAM_DATA_W-1:0]  ram_out_ii,
    output logic [RAM_ADDR_W-1:0]  ram_write_addr,
    output logic [RAM_DATA_W-1:0]  ram_write_data,
    output logic                   ram_we
);
    adapter_state_e        state_q, state_d;
    logic [RAM_ADDR_W-1:0] h, h_eff, hi_addr_q;
    logic [RAM_DATA_W-1:0] hi_data_q;
    logic                  is_word, fault, accept, word_st, in_hi;
    logic [31:0]           load_data, rsp_rdata_d;
    logic                  rsp_valid_d, rsp_err_d;

    assign h       = req_addr[BYTE_ADDR_W-1:1];
    assign is_word = req_size[1];
    // Word accesses always use an even halfword pair; without fault checking this
    // is what silently aligns a misaligned word.
    assign h_eff   = is_word ? {h[RAM_ADDR_W-1:1], 1'b0} : h;

`ifdef MEM_ACCESS_FAULT_EN
    assign fault = (req_size == SIZE_HALF && req_addr[0]) ||
                   (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) ||
                   req_size == 2'b11;
`else
    assign fault = 1'b0;
`endif

    assign in_hi       = state_q == WR_HI;
    assign req_ready   = state_q == IDLE;
    assign accept      = req_valid & req_ready;
    assign word_st     = accept & req_we & is_word & ~fault;
    assign ram_read_i  = h_eff;
    assign ram_read_ii = h_eff + 1'b1;

    mem_load_align u_align (
        .data_i     ({ram_out_ii, ram_out_i}),
        .size_i     (req_size),
        .lane_i     (req_addr[0]),
        .unsigned_i (req_unsigned),
        .result_o   (load_data)
    );

    assign ram_we         = ~RST & (in_hi | (accept & req_we & ~fault));
    assign ram_write_addr = in_hi ? hi_addr_q : h_eff;
    // Byte store merges into the pre-write halfword seen on the async read port.
    assign ram_write_data = in_hi ? hi_data_q :
                            req_size == SIZE_BYTE ?
                                (req_addr[0] ? {req_wdata[7:0], ram_out_i[7:0]}
                                             : {ram_out_i[15:8], req_wdata[7:0]}) :
                            req_wdata[15:0];

    always_comb begin
        state_d     = word_st ? WR_HI : IDLE;
        rsp_valid_d = in_hi | (accept & ~word_st);
        rsp_rdata_d = rsp_valid_d ? ((accept & ~req_we & ~fault) ? load_data : 32'h0) : rsp_rdata;
        rsp_err_d   = accept & fault;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            hi_addr_q <= '0;
            hi_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            if (word_st) begin
                hi_addr_q <= ram_read_ii;
                hi_data_q <= req_wdata[31:16];
            end
        end
    end
endmodule

// File: doc/mem_word_adapter.md
Name: mem_word_adapter

Overview:
- Sits directly upstream of the 256x16 distributed RAM: the multi-cycle core's single memory port in, RAM read/write ports out.
- Converts 32-bit RISC-V byte-addressed loads and stores into 16-bit halfword RAM accesses.
- Supports byte, half and word sizes; byte stores via same-cycle read-modify-write; word stores in two write cycles; load sign/zero extension.

Parameters:
- RAM_ADDR_W, 8, RAM halfword address width.
- RAM_DATA_W, 16, RAM word width; fixed at 16, other values unsupported.
- BYTE_ADDR_W, RAM_ADDR_W+1, core-side byte address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  adapter can accept; equals (state==IDLE).
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as fault.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  BYTE_ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; 0 for stores.
- rsp_err  out  1  fault flag, qualified by rsp_valid.
- ram_read_i  out  RAM_ADDR_W  RAM async read port 1 address.
- ram_read_ii  out  RAM_ADDR_W  RAM async read port 2 address.
- ram_out_i  in  16  RAM port 1 data.
- ram_out_ii  in  16  RAM port 2 data.
- ram_write_addr  out  RAM_ADDR_W  RAM write address.
- ram_write_data  out  16  RAM write data.
- ram_we  out  1  RAM write enable, sampled by the RAM on CLK.

Behaviour:
- Addressing and data layout:
  - Little-endian. Halfword index h = req_addr[BYTE_ADDR_W-1:1]; byte lane = req_addr[0].
  - Word = {mem[h+1], mem[h]}.
- States: IDLE, WR_HI.
  - Reset: state IDLE; rsp_valid, rsp_rdata and rsp_err = 0.
  - ram_we is forced 0 while RST is high.
- IDLE, on accept (req_valid & req_ready):
  - ram_read_i = h and ram_read_ii = h+1, driven combinationally from req_addr. h+1 wraps mod 2^RAM_ADDR_W; this never matters for aligned words.
  - Load: result extracted from ram_out_i/ram_out_ii in the same cycle and registered. rsp_valid=1 next cycle, so latency is 1. Back-to-back loads run one per cycle.
  - Byte load: selects ram_out_i[7:0] or [15:8] per lane, then extends to 32. Half load: extends ram_out_i.
  - Half store: ram_we=1, write_addr=h, write_data=wdata[15:0]. rsp_valid next cycle.
  - Byte store: ram_we=1, write_addr=h. write_data = ram_out_i with the selected lane replaced by wdata[7:0] (RMW in one cycle; async read returns pre-write data). rsp_valid next cycle.
  - Word store, low half: ram_we=1, addr=h, data=wdata[15:0]. The adapter latches h+1 and wdata[31:16], then goes to WR_HI.
- WR_HI:
  - ram_we=1, addr=latched h+1, data=latched high half.
  - Next cycle: state IDLE and rsp_valid=1, so a word store has latency 2.
  - req_ready=0 throughout WR_HI.
- rsp_valid is high exactly one cycle per request. A new request may be accepted in the same cycle rsp_valid is high.
- Idle: ram_we=0 when there is no accept and state is IDLE. rsp_rdata holds its last value while rsp_valid is low.
- Reset during WR_HI: the high half is abandoned (low half already written), no response, state IDLE.

Optional Feature:
- MEM_ACCESS_FAULT_EN defined:
  - Faulting requests: half at odd address, word with addr[1:0]!=0, or size 11.
  - Effect: ram_we stays 0, rsp_valid next cycle with rsp_err=1 and rsp_rdata=0.
- Undefined:
  - rsp_err is tied 0.
  - Misaligned addresses are force-aligned: half ignores addr[0]; word ignores addr[1:0].
  - Size 11 is treated as word.

Decomposition:
- Package mem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - Adapter state enum (IDLE, WR_HI).
  - RAM_ADDR_W/RAM_DATA_W defaults.
- One combinational sub-module, mem_load_align: lane select plus sign/zero extension from {ram_out_ii, ram_out_i}, size, lane and unsigned flag to a 32-bit result. The top module keeps the FSM, RMW merge and response registers.

Test Plan:
- Word store 0xDEADBEEF to addr 0x010 -> write h=0x08 data 0xBEEF, then h=0x09 data 0xDEAD on the next cycle. rsp_valid 2 cycles after accept. Word load 0x010 returns 0xDEADBEEF, 1 cycle latency.
- mem[0x08]=0xBEEF; signed byte load addr 0x011 -> 0xFFFFFFBE. Unsigned -> 0x000000BE. Signed half load 0x010 -> 0xFFFFBEEF.
- Byte store 0x5A to addr 0x011 with mem[0x08]=0xBEEF -> single write 0x5AEF to h=0x08. mem[0x09] untouched.
- Four back-to-back loads with req_valid held -> req_ready constant 1 and four consecutive rsp_valid pulses. A word store mid-stream -> req_ready low exactly one cycle.
- MEM_ACCESS_FAULT_EN defined, word store to 0x012 -> no ram_we, rsp_err=1, rsp_rdata=0. Undefined -> writes land at h=0x08/0x09, rsp_err=0.
- Assert RST during WR_HI of word store 0x12345678 at 0x020 -> mem[0x10]=0x5678, mem[0x11] unchanged, no rsp_valid, req_ready=1 after reset release.
